// File: rtl/gbe_txs_pkg.sv
// Shared types and helpers for the 10GbE software TX buffer read path.
package gbe_txs_pkg;

    localparam int GBE_AW = 13;
    localparam int GBE_DW = 128;
    localparam int GBE_KW = GBE_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    // A last-word byte count of 0 means the final word is completely full.
    function automatic logic [GBE_KW-1:0] keep_from_last_bytes(input logic [3:0] last_bytes);
        logic [GBE_KW-1:0] keep;
        if (last_bytes == 4'd0) begin
            keep = '1;
        end else begin
            keep = (GBE_KW'(1) << last_bytes) - GBE_KW'(1);
        end
        return keep;
    endfunction

endpackage

// File: rtl/gbe_txs_skid_fifo.sv
// Small synchronous FIFO holding {last, data} beats between the BRAM and the TX stream.
module gbe_txs_skid_fifo
    import gbe_txs_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = GBE_DW + 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gbe_txs_frame_reader.sv
// Reads one frame from the TX buffer BRAM port A per send command and streams it to the MAC FIFO.
module gbe_txs_frame_reader
    import gbe_txs_pkg::*;
#(
    parameter int AW         = GBE_AW,
    parameter int DW         = GBE_DW,
    parameter int KW         = GBE_KW,
    parameter int SKID_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_start_addr,
    input  logic [AW-1:0] cmd_len_words,
    input  logic [3:0]    cmd_last_bytes,
    output logic          bram_en_a,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_rd_data,
    output logic [DW-1:0] bram_wr_data,
    output logic [DW-1:0] tx_data,
    output logic [KW-1:0] tx_keep,
    output logic          tx_valid,
    output logic          tx_eof,
    input  logic          tx_ready,
    output logic          frame_done,
    output logic [31:0]   frames_sent
);

    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int OW = CW + 1;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rem_q;
    logic [3:0]    last_bytes_q;
    logic          inflight_q;
    logic          inflight_last_q;
    logic          done_q;
    logic [31:0]   frames_q;

    logic          cmd_fire;
    logic          pop;
    logic          eof_retire;
    logic          last_issue;
    logic [DW:0]   head;
    logic          head_last;
    logic [DW-1:0] head_data;
    logic [CW-1:0] skid_count;
    logic [OW-1:0] occupancy;

    gbe_txs_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .W     (DW + 1),
        .CW    (CW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bram_rd_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (skid_count)
    );

    assign head_last  = head[DW];
    assign head_data  = head[DW-1:0];
    assign cmd_ready  = (state == ST_IDLE) && rst_n;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign tx_valid   = (skid_count != '0);
    assign pop        = tx_valid && tx_ready;
    assign eof_retire = pop && head_last;
    assign last_issue = (rem_q == AW'(1));

    // Counting the beat retiring this cycle as free lets a read refill it at once,
    // which sustains one beat per cycle with only two skid entries.
    assign occupancy  = OW'(skid_count) + OW'(inflight_q) - OW'(pop);

    always_comb begin
        state_nxt = state;
        bram_en_a = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire && (cmd_len_words != '0)) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (occupancy < OW'(SKID_DEPTH)) begin
                    bram_en_a = 1'b1;
                    if (last_issue) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (eof_retire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            last_bytes_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            frames_q        <= '0;
        end else begin
            state           <= state_nxt;
            inflight_q      <= bram_en_a;
            inflight_last_q <= bram_en_a && last_issue;
            done_q          <= 1'b0;
            if (cmd_fire) begin
                addr_q       <= cmd_start_addr;
                rem_q        <= cmd_len_words;
                last_bytes_q <= cmd_last_bytes;
                if (cmd_len_words == '0) begin
                    done_q <= 1'b1;
                end
            end
            if (bram_en_a) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
            if (eof_retire) begin
                done_q   <= 1'b1;
                frames_q <= frames_q + 32'd1;
            end
        end
    end

    always_comb begin
        tx_data = '0;
        tx_keep = '0;
        tx_eof  = 1'b0;
        if (tx_valid) begin
            tx_data = head_data;
            tx_eof  = head_last;
            tx_keep = head_last ? KW'(keep_from_last_bytes(last_bytes_q)) : '1;
        end
    end

    assign bram_addr    = addr_q;
    assign bram_we      = 1'b0;
    assign bram_wr_data = '0;
    assign frame_done   = done_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_gbe_txs_frame_reader.sv
// Directed self-checking bench for gbe_txs_frame_reader with a behavioural BRAM port A.
module tb_gbe_txs_frame_reader;

    localparam int AW = 13;
    localparam int DW = 128;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_start_addr = '0;
    logic [AW-1:0] cmd_len_words = '0;
    logic [3:0]    cmd_last_bytes = '0;
    logic          bram_en_a;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rd_data = '0;
    logic [DW-1:0] bram_wr_data;
    logic [DW-1:0] tx_data;
    logic [KW-1:0] tx_keep;
    logic          tx_valid;
    logic          tx_eof;
    logic          tx_ready = 1'b0;
    logic          frame_done;
    logic [31:0]   frames_sent;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [AW-1:0] addr_q[$];
    int            en_cyc_q[$];
    logic [DW-1:0] dat_q[$];
    logic [KW-1:0] keep_q[$];
    logic          eof_q[$];
    int            beat_cyc_q[$];
    int            done_cyc_q[$];
    int            stable_err = 0;
    int            out_cnt = 0;
    int            max_out = 0;
    logic          prev_stall = 1'b0;
    logic [DW+KW:0] prev_beat = '0;

    gbe_txs_frame_reader #(
        .AW(AW), .DW(DW), .KW(KW), .SKID_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start_addr(cmd_start_addr), .cmd_len_words(cmd_len_words),
        .cmd_last_bytes(cmd_last_bytes),
        .bram_en_a(bram_en_a), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_rd_data(bram_rd_data), .bram_wr_data(bram_wr_data),
        .tx_data(tx_data), .tx_keep(tx_keep), .tx_valid(tx_valid),
        .tx_eof(tx_eof), .tx_ready(tx_ready),
        .frame_done(frame_done), .frames_sent(frames_sent)
    );

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {32'hC0DE0000 ^ x, x * 32'h9E3779B9, ~x, 32'h5A5A5A5A + (x << 7)};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bram_en_a) bram_rd_data <= word_of(bram_addr);

    // Records reads, retired beats and frame_done pulses late in each cycle.
    always @(posedge clk) begin
        #4;
        if (!rst_n) begin
            prev_stall = 1'b0;
            out_cnt = 0;
        end else begin
            if (bram_en_a) begin
                addr_q.push_back(bram_addr);
                en_cyc_q.push_back(cyc);
            end
            if (tx_valid && tx_ready) begin
                dat_q.push_back(tx_data);
                keep_q.push_back(tx_keep);
                eof_q.push_back(tx_eof);
                beat_cyc_q.push_back(cyc);
            end
            if (frame_done) done_cyc_q.push_back(cyc);
            if (prev_stall && (!tx_valid || {tx_eof, tx_keep, tx_data} != prev_beat))
                stable_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_beat = {tx_eof, tx_keep, tx_data};
            out_cnt = out_cnt + (bram_en_a ? 1 : 0) - ((tx_valid && tx_ready) ? 1 : 0);
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_queues();
        addr_q.delete(); en_cyc_q.delete(); dat_q.delete(); keep_q.delete();
        eof_q.delete(); beat_cyc_q.delete(); done_cyc_q.delete();
        stable_err = 0;
        max_out = 0;
    endtask

    task automatic issue_cmd(input logic [AW-1:0] start, input logic [AW-1:0] len,
                             input logic [3:0] lb, output int n);
        int k;
        tick();
        cmd_valid = 1'b1;
        cmd_start_addr = start;
        cmd_len_words = len;
        cmd_last_bytes = lb;
        #2;
        k = 0;
        while (!cmd_ready && k < 50) begin
            tick();
            #2;
            k++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL cmd_handshake_timeout: got cmd_ready=%b expected 1", cmd_ready);
        end
        n = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_start_addr = ~start;
        cmd_len_words = len + 5;
        cmd_last_bytes = lb ^ 4'hA;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        #2;
        tests++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        tests++; if (bram_en_a !== 1'b0) begin failed++; $display("FAIL reset_bram_en: got %b expected 0", bram_en_a); end
        tests++; if (bram_addr !== '0) begin failed++; $display("FAIL reset_bram_addr: got %h expected 0", bram_addr); end
        tests++; if (tx_valid !== 1'b0 || tx_eof !== 1'b0) begin failed++; $display("FAIL reset_tx_flags: got valid=%b eof=%b expected 0 0", tx_valid, tx_eof); end
        tests++; if (tx_keep !== '0 || tx_data !== '0) begin failed++; $display("FAIL reset_tx_bus: got keep=%h data=%h expected 0", tx_keep, tx_data); end
        tests++; if (frame_done !== 1'b0 || frames_sent !== 32'd0) begin failed++; $display("FAIL reset_counters: got done=%b sent=%0d expected 0 0", frame_done, frames_sent); end
        tests++; if (bram_we !== 1'b0 || bram_wr_data !== '0) begin failed++; $display("FAIL reset_write_port: got we=%b wdata=%h expected 0", bram_we, bram_wr_data); end
        tick();
        rst_n = 1'b1;
        tick();
        #2;
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_basic();
        int n;
        clear_queues();
        tx_ready = 1'b1;
        issue_cmd(13'h0010, 13'd4, 4'd0, n);
        repeat (12) tick();
        tests++; if (addr_q.size() != 4) begin failed++; $display("FAIL basic_reads: got %0d expected 4", addr_q.size()); end
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            tests++; if (addr_q[i] !== AW'(16 + i)) begin failed++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, addr_q[i], AW'(16 + i)); end
        end
        tests++; if (en_cyc_q.size() == 0 || en_cyc_q[0] != n + 1) begin failed++; $display("FAIL basic_first_read_cycle: got %0d expected %0d", (en_cyc_q.size() == 0) ? -1 : en_cyc_q[0] - n, 1); end
        tests++; if (dat_q.size() != 4) begin failed++; $display("FAIL basic_beats: got %0d expected 4", dat_q.size()); end
        for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
            tests++; if (dat_q[i] !== word_of(AW'(16 + i))) begin failed++; $display("FAIL basic_data[%0d]: got %h expected %h", i, dat_q[i], word_of(AW'(16 + i))); end
            tests++; if (keep_q[i] !== 16'hFFFF) begin failed++; $display("FAIL basic_keep[%0d]: got %h expected ffff", i, keep_q[i]); end
            tests++; if (eof_q[i] !== (i == 3)) begin failed++; $display("FAIL basic_eof[%0d]: got %b expected %b", i, eof_q[i], (i == 3)); end
            tests++; if (beat_cyc_q[i] != n + 3 + i) begin failed++; $display("FAIL basic_beat_cycle[%0d]: got N+%0d expected N+%0d", i, beat_cyc_q[i] - n, 3 + i); end
        end
        tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != n + 7) begin failed++; $display("FAIL basic_frame_done: got %0d pulses first N+%0d expected 1 at N+7", done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0] - n); end
        tests++; if (frames_sent !== 32'd1) begin failed++; $display("FAIL basic_frames_sent: got %0d expected 1", frames_sent); end
    endtask

    task automatic test_wrap();
        int n;
        logic [AW-1:0] exp_addr;
        clear_queues();
        issue_cmd(13'h1FFF, 13'd3, 4'd5, n);
        repeat (10) tick();
        tests++; if (addr_q.size() != 3 || dat_q.size() != 3) begin failed++; $display("FAIL wrap_counts: got reads=%0d beats=%0d expected 3 3", addr_q.size(), dat_q.size()); end
        for (int i = 0; i < 3 && i < addr_q.size() && i < dat_q.size(); i++) begin
            exp_addr = AW'(13'h1FFF + i);
            tests++; if (addr_q[i] !== exp_addr) begin failed++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr_q[i], exp_addr); end
            tests++; if (dat_q[i] !== word_of(exp_addr)) begin failed++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, dat_q[i], word_of(exp_addr)); end
            tests++; if (keep_q[i] !== ((i == 2) ? 16'h001F : 16'hFFFF)) begin failed++; $display("FAIL wrap_keep[%0d]: got %h expected %h", i, keep_q[i], (i == 2) ? 16'h001F : 16'hFFFF); end
        end
        tests++; if (frames_sent !== 32'd2) begin failed++; $display("FAIL wrap_frames_sent: got %0d expected 2", frames_sent); end
    endtask

    task automatic test_backpressure();
        int n;
        int k;
        clear_queues();
        tx_ready = 1'b0;
        issue_cmd(13'h0100, 13'd6, 4'd9, n);
        k = 0;
        while (done_cyc_q.size() == 0 && k < 200) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        tx_ready = 1'b1;
        repeat (3) tick();
        tests++; if (done_cyc_q.size() != 1) begin failed++; $display("FAIL bp_frame_done: got %0d pulses expected 1", done_cyc_q.size()); end
        tests++; if (dat_q.size() != 6) begin failed++; $display("FAIL bp_beats: got %0d expected 6", dat_q.size()); end
        for (int i = 0; i < 6 && i < dat_q.size(); i++) begin
            tests++; if (dat_q[i] !== word_of(AW'(13'h100 + i))) begin failed++; $display("FAIL bp_data[%0d]: got %h expected %h", i, dat_q[i], word_of(AW'(13'h100 + i))); end
            tests++; if (eof_q[i] !== (i == 5)) begin failed++; $display("FAIL bp_eof[%0d]: got %b expected %b", i, eof_q[i], (i == 5)); end
            tests++; if (keep_q[i] !== ((i == 5) ? 16'h01FF : 16'hFFFF)) begin failed++; $display("FAIL bp_keep[%0d]: got %h expected %h", i, keep_q[i], (i == 5) ? 16'h01FF : 16'hFFFF); end
        end
        tests++; if (stable_err != 0) begin failed++; $display("FAIL bp_stall_stability: got %0d changes expected 0", stable_err); end
        tests++; if (max_out > 2) begin failed++; $display("FAIL bp_occupancy: got %0d expected <= 2", max_out); end
        tests++; if (frames_sent !== 32'd3) begin failed++; $display("FAIL bp_frames_sent: got %0d expected 3", frames_sent); end
    endtask

    task automatic test_empty();
        int n;
        clear_queues();
        issue_cmd(13'h0040, 13'd0, 4'd0, n);
        repeat (5) tick();
        tests++; if (addr_q.size() != 0 || dat_q.size() != 0) begin failed++; $display("FAIL empty_activity: got reads=%0d beats=%0d expected 0 0", addr_q.size(), dat_q.size()); end
        tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != n + 1) begin failed++; $display("FAIL empty_frame_done: got %0d pulses first N+%0d expected 1 at N+1", done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0] - n); end
        tests++; if (frames_sent !== 32'd3) begin failed++; $display("FAIL empty_frames_sent: got %0d expected 3", frames_sent); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int eofs;
        clear_queues();
        issue_cmd(13'h0200, 13'd8, 4'd0, n);
        while (cyc < n + 4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        tests++; if (bram_en_a !== 1'b0 || bram_addr !== '0) begin failed++; $display("FAIL rst_mid_bram: got en=%b addr=%h expected 0 0", bram_en_a, bram_addr); end
        tests++; if (tx_valid !== 1'b0 || tx_eof !== 1'b0 || tx_keep !== '0 || tx_data !== '0) begin failed++; $display("FAIL rst_mid_stream: got valid=%b eof=%b keep=%h expected 0 0 0", tx_valid, tx_eof, tx_keep); end
        tests++; if (frame_done !== 1'b0 || frames_sent !== 32'd0) begin failed++; $display("FAIL rst_mid_counters: got done=%b sent=%0d expected 0 0", frame_done, frames_sent); end
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready); end
        repeat (4) tick();
        eofs = 0;
        foreach (eof_q[i]) if (eof_q[i]) eofs++;
        tests++; if (eofs != 0 || done_cyc_q.size() != 0) begin failed++; $display("FAIL rst_mid_abandon: got eofs=%0d done=%0d expected 0 0", eofs, done_cyc_q.size()); end
        clear_queues();
        issue_cmd(13'h0300, 13'd1, 4'd3, n);
        repeat (8) tick();
        tests++; if (dat_q.size() != 1) begin failed++; $display("FAIL rst_new_beats: got %0d expected 1", dat_q.size()); end
        if (dat_q.size() == 1) begin
            tests++; if (dat_q[0] !== word_of(13'h0300)) begin failed++; $display("FAIL rst_new_data: got %h expected %h", dat_q[0], word_of(13'h0300)); end
            tests++; if (keep_q[0] !== 16'h0007 || eof_q[0] !== 1'b1) begin failed++; $display("FAIL rst_new_last: got keep=%h eof=%b expected 0007 1", keep_q[0], eof_q[0]); end
            tests++; if (beat_cyc_q[0] != n + 3) begin failed++; $display("FAIL rst_new_cycle: got N+%0d expected N+3", beat_cyc_q[0] - n); end
        end
        tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != n + 4) begin failed++; $display("FAIL rst_new_done: got %0d pulses expected 1 at N+4", done_cyc_q.size()); end
        tests++; if (frames_sent !== 32'd1) begin failed++; $display("FAIL rst_new_frames_sent: got %0d expected 1", frames_sent); end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        int k;
        logic [AW-1:0] exp_addr [5];
        logic [AW-1:0] a;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_queues();
        tx_ready = 1'b1;
        tick();
        cmd_valid = 1'b1;
        cmd_start_addr = 13'h0400; cmd_len_words = 13'd2; cmd_last_bytes = 4'd0;
        #2;
        k = 0;
        while (!cmd_ready && k < 50) begin tick(); #2; k++; end
        n1 = cyc;
        tick();
        cmd_start_addr = 13'h0500; cmd_len_words = 13'd3; cmd_last_bytes = 4'd1;
        #2;
        k = 0;
        while (!cmd_ready && k < 50) begin tick(); #2; k++; end
        n2 = cyc;
        tick();
        cmd_valid = 1'b0;
        repeat (12) tick();
        tests++; if (n2 != n1 + 5) begin failed++; $display("FAIL b2b_second_accept: got N+%0d expected N+5", n2 - n1); end
        tests++; if (done_cyc_q.size() != 2 || done_cyc_q[0] != n1 + 5 || done_cyc_q[1] != n2 + 6) begin failed++; $display("FAIL b2b_frame_done: got %0d pulses expected 2 at N1+5 N2+6", done_cyc_q.size()); end
        exp_addr = '{13'h0400, 13'h0401, 13'h0500, 13'h0501, 13'h0502};
        tests++; if (dat_q.size() != 5) begin failed++; $display("FAIL b2b_beats: got %0d expected 5", dat_q.size()); end
        for (int i = 0; i < 5 && i < dat_q.size(); i++) begin
            a = exp_addr[i];
            tests++; if (dat_q[i] !== word_of(a)) begin failed++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, dat_q[i], word_of(a)); end
            tests++; if (eof_q[i] !== (i == 1 || i == 4)) begin failed++; $display("FAIL b2b_eof[%0d]: got %b expected %b", i, eof_q[i], (i == 1 || i == 4)); end
        end
        if (keep_q.size() == 5) begin
            tests++; if (keep_q[4] !== 16'h0001) begin failed++; $display("FAIL b2b_last_keep: got %h expected 0001", keep_q[4]); end
        end
        tests++; if (frames_sent !== 32'd2) begin failed++; $display("FAIL b2b_frames_sent: got %0d expected 2", frames_sent); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_empty();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
